aes128_round_ctrl: RTL and testbench

//   Sequencing controller for the iterative AES-128 round datapath built from library cells.

---
 rtl/aes128_round_ctrl_if.sv | 29 ++
 rtl/aes128_round_ctrl.sv | 139 +++++++++++++
 tb/tb_aes128_round_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_round_ctrl_if.sv
// Block-level stream and datapath-strobe bundle for the AES-128 round controller.
// The controller uses the slave modport; the producer/consumer side uses master.
interface aes128_round_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       abort;
    logic       load_en;
    logic       round_en;
    logic       key_en;
    logic       last_round;
    logic [3:0] round_idx;
    logic [7:0] rcon;
    logic       irq;
    logic       irq_clr;

    modport master (
        output in_valid, out_ready, abort, irq_clr,
        input  in_ready, out_valid, load_en, round_en, key_en,
               last_round, round_idx, rcon, irq
    );

    modport slave (
        input  in_valid, out_ready, abort, irq_clr,
        output in_ready, out_valid, load_en, round_en, key_en,
               last_round, round_idx, rcon, irq
    );
endinterface

// File: rtl/aes128_round_ctrl.sv
// Sequencer for the iterative AES-128 round datapath: accept, round strobes, RCON, result hold.
// Optional sticky done interrupt is enabled by defining AES_DONE_IRQ_EN.
module aes128_round_ctrl #(
    parameter int NUM_ROUNDS       = 10,
    parameter int CYCLES_PER_ROUND = 1
) (
    input logic               CLK,
    input logic               RSTB,
    aes128_round_ctrl_if.slave bus
);

    localparam int              CNT_W    = (CYCLES_PER_ROUND > 1) ? $clog2(CYCLES_PER_ROUND) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_ROUND - 1);
    localparam logic [3:0]      IDX_LAST = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       rcon_q, rcon_d;

    logic in_ready;
    logic accept;
    logic strobe;
    logic last_round;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    always_comb begin
        // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
        in_ready   = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & bus.out_ready);
        accept     = bus.in_valid & in_ready & ~bus.abort;
        last_round = (state_q == ST_ROUND) & (idx_q == IDX_LAST);
        strobe     = (state_q == ST_ROUND) & (cnt_q == CNT_LAST) & ~bus.abort;

        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;

        if (bus.abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = 4'd0;
            rcon_d  = 8'h01;
        end else if (accept) begin
            // Covers both the idle accept and the back-to-back accept out of HOLD.
            state_d = ST_ROUND;
            cnt_d   = '0;
            idx_d   = 4'd1;
            rcon_d  = 8'h01;
        end else begin
            unique case (state_q)
                ST_ROUND: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        // The final round keeps its index and RCON visible through HOLD.
                        if (last_round) begin
                            state_d = ST_HOLD;
                        end else begin
                            idx_d  = idx_q + 4'd1;
                            rcon_d = xtime(rcon_q);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_d = ST_IDLE;
                        idx_d   = 4'd0;
                        rcon_d  = 8'h01;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 4'd0;
            rcon_q  <= 8'h01;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.load_en    = accept;
    assign bus.round_en   = strobe;
    assign bus.key_en     = strobe;
    assign bus.last_round = last_round;
    assign bus.out_valid  = (state_q == ST_HOLD);
    assign bus.round_idx  = idx_q;
    assign bus.rcon       = rcon_q;

`ifdef AES_DONE_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        // Set has priority over clear when both happen on the same edge.
        if (bus.out_valid & bus.out_ready) begin
            irq_d = 1'b1;
        end else if (bus.irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.irq = irq_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = bus.irq_clr;
    assign bus.irq        = 1'b0;
`endif

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Directed bench for aes128_round_ctrl: two instances (1 and 3 clocks per round) with a
// round-strobe scoreboard; IRQ expectations follow AES_DONE_IRQ_EN.
module tb_aes128_round_ctrl;

`ifdef AES_DONE_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    localparam logic [7:0] RCON_TBL [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                             8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    typedef struct {
        int         cyc;
        logic [3:0] idx;
        logic [7:0] rcon;
        logic       last;
    } exp_t;

    logic CLK = 1'b0;
    logic RSTB;
    always #5 CLK = ~CLK;

    aes128_round_ctrl_if b0 ();
    aes128_round_ctrl_if b1 ();

    aes128_round_ctrl #(.NUM_ROUNDS(10), .CYCLES_PER_ROUND(1)) u0 (
        .CLK (CLK),
        .RSTB(RSTB),
        .bus (b0.slave)
    );

    aes128_round_ctrl #(.NUM_ROUNDS(10), .CYCLES_PER_ROUND(3)) u1 (
        .CLK (CLK),
        .RSTB(RSTB),
        .bus (b1.slave)
    );

    exp_t sb0[$];
    exp_t sb1[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_block(input int d, input int a, input int cpr);
        exp_t e;
        for (int r = 1; r <= 10; r++) begin
            e.cyc  = a + r * cpr;
            e.idx  = 4'(r);
            e.rcon = RCON_TBL[r-1];
            e.last = (r == 10);
            if (d == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
    endtask

    task automatic mon(input int d, input logic re, input logic ke, input logic lr,
                       input logic [3:0] idx, input logic [7:0] rc);
        exp_t e;
        bit   have;
        check($sformatf("key_en_eq_round_en_u%0d", d), ke, re);
        if (re === 1'b1) begin
            have = (d == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
            check($sformatf("strobe_expected_u%0d", d), have, 1);
            if (have) begin
                if (d == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                check($sformatf("strobe_cycle_u%0d_r%0d", d, e.idx), cyc, e.cyc);
                check($sformatf("strobe_idx_u%0d_r%0d", d, e.idx), idx, e.idx);
                check($sformatf("strobe_rcon_u%0d_r%0d", d, e.idx), rc, e.rcon);
                check($sformatf("strobe_last_u%0d_r%0d", d, e.idx), lr, e.last);
            end
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        mon(0, b0.round_en, b0.key_en, b0.last_round, b0.round_idx, b0.rcon);
        mon(1, b1.round_en, b1.key_en, b1.last_round, b1.round_idx, b1.rcon);
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic idle_chk(input string tag, input logic ir, input logic ov, input logic re,
                            input logic ke, input logic lr, input logic [3:0] idx,
                            input logic [7:0] rc, input logic irq);
        check({tag, "_in_ready"}, ir, 1'b1);
        check({tag, "_out_valid"}, ov, 1'b0);
        check({tag, "_round_en"}, re, 1'b0);
        check({tag, "_key_en"}, ke, 1'b0);
        check({tag, "_last_round"}, lr, 1'b0);
        check({tag, "_round_idx"}, idx, 4'd0);
        check({tag, "_rcon"}, rc, 8'h01);
        check({tag, "_irq"}, irq, 1'b0);
    endtask

    task automatic wait_ov(input int d, input int limit, output int seen);
        seen = -1;
        for (int i = 0; i < limit; i++) begin
            if (((d == 0) ? b0.out_valid : b1.out_valid) === 1'b1) begin
                seen = cyc;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  a;
        int  seen;
        bit  ov_seen;

        RSTB = 1'b0;
        b0.in_valid = 1'b0; b0.out_ready = 1'b0; b0.abort = 1'b0; b0.irq_clr = 1'b0;
        b1.in_valid = 1'b0; b1.out_ready = 1'b0; b1.abort = 1'b0; b1.irq_clr = 1'b0;
        @(posedge CLK);
        #1;
        idle_chk("rst_u0", b0.in_ready, b0.out_valid, b0.round_en, b0.key_en, b0.last_round,
                 b0.round_idx, b0.rcon, b0.irq);
        idle_chk("rst_u1", b1.in_ready, b1.out_valid, b1.round_en, b1.key_en, b1.last_round,
                 b1.round_idx, b1.rcon, b1.irq);
        tick();
        tick();
        RSTB = 1'b1;
        tick();

        // Single block, consumer stalls the result.
        b0.in_valid = 1'b1;
        #1;
        check("t2_load_en", b0.load_en, 1'b1);
        a = cyc;
        push_block(0, a, 1);
        tick();
        b0.in_valid = 1'b0;
        check("t2_idx_r1", b0.round_idx, 4'd1);
        check("t2_in_ready_busy", b0.in_ready, 1'b0);
        wait_ov(0, 40, seen);
        check("t2_latency", seen, a + 11);
        check("t2_sb_drained", sb0.size(), 0);

        for (int i = 0; i < 7; i++) begin
            check("t4_hold_out_valid", b0.out_valid, 1'b1);
            check("t4_hold_idx", b0.round_idx, 4'd10);
            check("t4_hold_rcon", b0.rcon, 8'h36);
            check("t4_hold_last_round", b0.last_round, 1'b0);
            check("t4_hold_load_en", b0.load_en, 1'b0);
            tick();
        end

        // Back-to-back accept straight out of HOLD.
        b0.in_valid  = 1'b1;
        b0.out_ready = 1'b1;
        #1;
        check("t4_b2b_load_en", b0.load_en, 1'b1);
        check("t4_b2b_in_ready", b0.in_ready, 1'b1);
        a = cyc;
        push_block(0, a, 1);
        tick();
        b0.in_valid  = 1'b0;
        b0.out_ready = 1'b0;
        check("t4_b2b_idx", b0.round_idx, 4'd1);
        check("t4_b2b_rcon", b0.rcon, 8'h01);
        check("t4_b2b_out_valid", b0.out_valid, 1'b0);
        check("t6_irq_after_done", b0.irq, IRQ_ON);

        // Abort in the round-4 strobe cycle while a new block is offered.
        tick();
        tick();
        tick();
        check("t5_idx_r4", b0.round_idx, 4'd4);
        b0.abort    = 1'b1;
        b0.in_valid = 1'b1;
        #1;
        check("t5_abort_round_en", b0.round_en, 1'b0);
        check("t5_abort_key_en", b0.key_en, 1'b0);
        check("t5_abort_load_en", b0.load_en, 1'b0);
        sb0.delete();
        tick();
        check("t5_idle_idx", b0.round_idx, 4'd0);
        check("t5_idle_rcon", b0.rcon, 8'h01);
        check("t5_idle_in_ready", b0.in_ready, 1'b1);
        check("t5_idle_load_en", b0.load_en, 1'b0);
        b0.abort    = 1'b0;
        b0.in_valid = 1'b0;
        ov_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            ov_seen |= (b0.out_valid !== 1'b0);
            tick();
        end
        check("t5_out_valid_never", ov_seen, 1'b0);

        // Three clocks per round on the second instance.
        b1.in_valid  = 1'b1;
        b1.out_ready = 1'b1;
        #1;
        check("t3_load_en", b1.load_en, 1'b1);
        a = cyc;
        push_block(1, a, 3);
        tick();
        b1.in_valid = 1'b0;
        check("t3_idx_c0", b1.round_idx, 4'd1);
        tick();
        check("t3_idx_c1", b1.round_idx, 4'd1);
        tick();
        check("t3_idx_c2", b1.round_idx, 4'd1);
        tick();
        check("t3_idx_r2", b1.round_idx, 4'd2);
        check("t3_rcon_r2", b1.rcon, 8'h02);
        wait_ov(1, 60, seen);
        check("t3_latency", seen, a + 31);
        check("t3_sb_drained", sb1.size(), 0);
        check("t3_hold_in_ready", b1.in_ready, 1'b1);
        tick();
        check("t3_idle_out_valid", b1.out_valid, 1'b0);
        check("t3_idle_idx", b1.round_idx, 4'd0);
        check("t3_idle_rcon", b1.rcon, 8'h01);
        check("t3_irq", b1.irq, IRQ_ON);
        b1.out_ready = 1'b0;

        // Reset for three cycles in the middle of round 5.
        b0.in_valid = 1'b1;
        #1;
        a = cyc;
        push_block(0, a, 1);
        tick();
        b0.in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        check("t1_idx_r5", b0.round_idx, 4'd5);
        RSTB = 1'b0;
        sb0.delete();
        #1;
        idle_chk("t1_in_rst", b0.in_ready, b0.out_valid, b0.round_en, b0.key_en, b0.last_round,
                 b0.round_idx, b0.rcon, b0.irq);
        tick(); tick(); tick();
        RSTB = 1'b1;
        #1;
        idle_chk("t1_post_rst", b0.in_ready, b0.out_valid, b0.round_en, b0.key_en, b0.last_round,
                 b0.round_idx, b0.rcon, b0.irq);
        for (int i = 0; i < 15; i++) tick();
        check("t1_no_replay_idx", b0.round_idx, 4'd0);

        // Done interrupt: set, set-beats-clear, clear alone.
        b0.in_valid  = 1'b1;
        b0.out_ready = 1'b1;
        #1;
        a = cyc;
        push_block(0, a, 1);
        tick();
        b0.in_valid = 1'b0;
        wait_ov(0, 40, seen);
        check("t6_latency_a", seen, a + 11);
        tick();
        check("t6_irq_set", b0.irq, IRQ_ON);
        b0.in_valid = 1'b1;
        #1;
        a = cyc;
        push_block(0, a, 1);
        tick();
        b0.in_valid = 1'b0;
        wait_ov(0, 40, seen);
        check("t6_latency_b", seen, a + 11);
        b0.irq_clr = 1'b1;
        tick();
        check("t6_irq_set_wins", b0.irq, IRQ_ON);
        tick();
        check("t6_irq_cleared", b0.irq, 1'b0);
        b0.irq_clr = 1'b0;
        tick();
        check("t6_irq_stays_clear", b0.irq, 1'b0);
        check("t6_sb_drained", sb0.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
